// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   UART transmitter fed by a write-side FIFO. Words enter through a
//   valid/ready handshake, are buffered, and leave as serial frames
//   (start, DATA_BITS payload LSB first, optional parity, STOP_BITS stop
//   bits) with no idle gap between consecutive frames.
//
// Ports
//   sys_clk       in   clock, all logic on the rising edge
//   sys_rst_n     in   synchronous active-low reset
//   tx_valid      in   tx_data is valid this cycle
//   tx_data       in   payload word, LSB transmitted first
//   tx_ready      out  FIFO can accept a word this cycle
//   uart_txd      out  registered serial line, idle high
//   uart_tx_busy  out  FIFO non-empty or frame in progress
//   fifo_count    out  number of stored words, 0..FIFO_DEPTH
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLK_FREQUENCY = 10_000_000,
  parameter int UART_BPS      = 115200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BPS_CNT = CLK_FREQUENCY / UART_BPS;
  localparam int BAUD_W  = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int BIT_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t               state_q,  state_d;
  logic [BAUD_W-1:0]    baud_q,   baud_d;
  logic [BIT_W-1:0]     bit_q,    bit_d;
  logic [DATA_BITS-1:0] shift_q,  shift_d;
  logic                 par_q,    par_d;
  logic                 txd_q,    txd_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q,  count_d;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic                 wr_en;
  logic                 pop;
  logic                 fifo_empty;
  logic                 baud_end;
  logic [DATA_BITS-1:0] head;

  // Ready depends only on the registered count, so a pop in the same cycle
  // never opens a slot while full.
  assign tx_ready     = (count_q != CNT_W'(FIFO_DEPTH));
  assign fifo_empty   = (count_q == '0);
  assign wr_en        = tx_valid && tx_ready;
  assign baud_end     = (baud_q == BAUD_W'(BPS_CNT - 1));
  assign head         = mem_q[rd_ptr_q];

  assign uart_txd     = txd_q;
  assign uart_tx_busy = (state_q != ST_IDLE) || !fifo_empty;
  assign fifo_count   = count_q;

  // Frame sequencer. Each state lasts BPS_CNT cycles per bit; STOP repeats
  // STOP_BITS times and chains directly into the next START when data waits.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      ST_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      ST_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      ST_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // The head word is captured together with its parity at pop time so the
    // FIFO slot can be reused immediately.
    if (pop) begin
      shift_d = head;
      par_d   = (PARITY == 1) ? ~^head : ^head;
    end
  end

  // Line level follows the current state one cycle later; this delay is the
  // same for every bit, so frame and bit lengths are preserved exactly.
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_q[0];
      ST_PARITY: txd_d = par_q;
      default:   txd_d = 1'b1;
    endcase
  end

  // FIFO bookkeeping; pointers wrap naturally because the depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_en ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop   ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      txd_q    <= txd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; resetting the pointers and count flushes it.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_n && wr_en) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo. Four instances cover 8N1, 8E2, 8O1 and
//   7O1 framing (all BPS_CNT = 86). Index 0..3 selects the instance.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int BPS = 86;

  logic       clk;
  logic       rst_n;
  logic       valid [4];
  logic [8:0] data  [4];
  logic       ready [4];
  logic       txd   [4];
  logic       busy  [4];
  logic [4:0] cnt   [4];

  int tests;
  int fails;

  uart_tx_fifo u_8n1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .tx_valid(valid[0]), .tx_data(data[0][7:0]),
    .tx_ready(ready[0]), .uart_txd(txd[0]), .uart_tx_busy(busy[0]), .fifo_count(cnt[0])
  );

  uart_tx_fifo #(.PARITY(2), .STOP_BITS(2)) u_8e2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .tx_valid(valid[1]), .tx_data(data[1][7:0]),
    .tx_ready(ready[1]), .uart_txd(txd[1]), .uart_tx_busy(busy[1]), .fifo_count(cnt[1])
  );

  uart_tx_fifo #(.PARITY(1)) u_8o1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .tx_valid(valid[2]), .tx_data(data[2][7:0]),
    .tx_ready(ready[2]), .uart_txd(txd[2]), .uart_tx_busy(busy[2]), .fifo_count(cnt[2])
  );

  uart_tx_fifo #(.DATA_BITS(7), .PARITY(1)) u_7o1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .tx_valid(valid[3]), .tx_data(data[3][6:0]),
    .tx_ready(ready[3]), .uart_txd(txd[3]), .uart_tx_busy(busy[3]), .fifo_count(cnt[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    for (int d = 0; d < 4; d++) begin
      tests++;
      if (txd[d] !== 1'b1) begin
        fails++;
        $display("FAIL reset_txd[%0d]: got %b want 1", d, txd[d]);
      end
      tests++;
      if (ready[d] !== 1'b1) begin
        fails++;
        $display("FAIL reset_ready[%0d]: got %b want 1", d, ready[d]);
      end
      tests++;
      if (busy[d] !== 1'b0) begin
        fails++;
        $display("FAIL reset_busy[%0d]: got %b want 0", d, busy[d]);
      end
      tests++;
      if (cnt[d] !== 5'd0) begin
        fails++;
        $display("FAIL reset_count[%0d]: got %0d want 0", d, cnt[d]);
      end
    end
    rst_n = 1'b1;
    tick;
  endtask

  // Write one word into an idle instance and check the whole frame cycle by
  // cycle. frame holds the expected line bits, first-transmitted bit at [0].
  task automatic send_and_check(input int d, input logic [8:0] word,
                                input logic [11:0] frame, input int nbits,
                                input string name);
    int   bit_cycles;
    int   bad_txd;
    int   bad_busy;
    int   first_c;
    logic exp_txd;
    logic exp_busy;
    logic t1;
    logic t2;
    logic got_first;
    bit_cycles = nbits * BPS;
    bad_txd    = 0;
    bad_busy   = 0;
    first_c    = -1;
    got_first  = 1'b0;
    t1         = 1'bx;
    t2         = 1'bx;
    valid[d] = 1'b1;
    data[d]  = word;
    tick;
    valid[d] = 1'b0;
    tests++;
    if (cnt[d] !== 5'd1 || busy[d] !== 1'b1) begin
      fails++;
      $display("FAIL %s_accept: count %0d busy %b want count 1 busy 1", name, cnt[d], busy[d]);
    end
    for (int c = 1; c <= bit_cycles + 5; c++) begin
      tick;
      if (c < 2)                   exp_txd = 1'b1;
      else if (c - 2 < bit_cycles) exp_txd = frame[(c - 2) / BPS];
      else                         exp_txd = 1'b1;
      exp_busy = (c <= bit_cycles);
      if (c == 1) t1 = txd[d];
      if (c == 2) t2 = txd[d];
      if (txd[d] !== exp_txd) begin
        bad_txd++;
        if (first_c < 0) begin
          first_c   = c;
          got_first = txd[d];
        end
      end
      if (busy[d] !== exp_busy) bad_busy++;
    end
    tests++;
    if ({t1, t2} !== 2'b10) begin
      fails++;
      $display("FAIL %s_latency: txd at E+1,E+2 = %b%b want 10", name, t1, t2);
    end
    tests++;
    if (bad_txd !== 0) begin
      fails++;
      $display("FAIL %s_frame: %0d bad cycles, first at E+%0d got %b", name, bad_txd, first_c, got_first);
    end
    tests++;
    if (bad_busy !== 0) begin
      fails++;
      $display("FAIL %s_busy: %0d cycles wrong, want high through E+%0d then low", name, bad_busy, bit_cycles);
    end
    tests++;
    if (cnt[d] !== 5'd0) begin
      fails++;
      $display("FAIL %s_drain: count %0d want 0", name, cnt[d]);
    end
  endtask

  task automatic test_8n1;
    // 0x55: start 0, data 1,0,1,0,1,0,1,0, stop 1
    send_and_check(0, 9'h055, 12'b0010_1010_1010, 10, "8n1_55");
  endtask

  task automatic test_parity;
    // Even parity, 2 stop: 0,1,1,1,0,0,0,0,0, parity 1, stop 1,1
    send_and_check(1, 9'h007, 12'b1110_0000_1110, 12, "8e2_07");
    // Odd parity: 0,1,1,1,0,0,0,0,0, parity 0, stop 1
    send_and_check(2, 9'h007, 12'b0100_0000_1110, 11, "8o1_07");
    // 7 bits odd: 0,1,0,0,0,0,0,1, parity 1, stop 1
    send_and_check(3, 9'h041, 12'b0011_1000_0010, 10, "7o1_41");
  endtask

  // 17 words with tx_valid held high. The first is popped at E1 (same edge
  // as a write), so all 17 fit: 1 in flight plus 16 buffered. A further word
  // is then refused while full, including across the pop edge at E861.
  task automatic test_back_to_back;
    int   total;
    int   bad_txd;
    int   bad_busy;
    int   first_c;
    int   f;
    int   b;
    logic exp_txd;
    logic [7:0] w;
    total    = 17 * 860 + 4;
    bad_txd  = 0;
    bad_busy = 0;
    first_c  = -1;
    for (int c = 0; c <= total; c++) begin
      if (c <= 16) begin
        valid[0] = 1'b1;
        data[0]  = 9'(c);
      end else if (c <= 861) begin
        valid[0] = 1'b1;
        data[0]  = 9'h011;
      end else begin
        valid[0] = 1'b0;
      end
      tick;
      if (c < 2) begin
        exp_txd = 1'b1;
      end else begin
        f = (c - 2) / 860;
        b = ((c - 2) % 860) / BPS;
        w = 8'(f);
        if (f >= 17)     exp_txd = 1'b1;
        else if (b == 0) exp_txd = 1'b0;
        else if (b <= 8) exp_txd = w[b - 1];
        else             exp_txd = 1'b1;
      end
      if (txd[0] !== exp_txd) begin
        bad_txd++;
        if (first_c < 0) first_c = c;
      end
      if (busy[0] !== (c <= 17 * 860)) bad_busy++;
      if (c == 16) begin
        tests++;
        if (cnt[0] !== 5'd16) begin
          fails++;
          $display("FAIL full_count: got %0d want 16", cnt[0]);
        end
        tests++;
        if (ready[0] !== 1'b0) begin
          fails++;
          $display("FAIL full_ready: got %b want 0", ready[0]);
        end
      end
      if (c == 17) begin
        tests++;
        if (cnt[0] !== 5'd16) begin
          fails++;
          $display("FAIL refused_write: count %0d want 16", cnt[0]);
        end
      end
      if (c >= 860 && c <= 16 * 860 + 1 && (c % 860) <= 1) begin
        tests++;
        if (c % 860 == 0) begin
          if (cnt[0] !== 5'(17 - c / 860)) begin
            fails++;
            $display("FAIL pre_pop_count@%0d: got %0d want %0d", c, cnt[0], 17 - c / 860);
          end
        end else begin
          if (cnt[0] !== 5'(16 - c / 860)) begin
            fails++;
            $display("FAIL post_pop_count@%0d: got %0d want %0d", c, cnt[0], 16 - c / 860);
          end
        end
      end
    end
    tests++;
    if (bad_txd !== 0) begin
      fails++;
      $display("FAIL stream_txd: %0d bad cycles, first at E0+%0d", bad_txd, first_c);
    end
    tests++;
    if (bad_busy !== 0) begin
      fails++;
      $display("FAIL stream_busy: %0d cycles wrong, want low from E0+%0d", bad_busy, 17 * 860 + 1);
    end
  endtask

  // Six words leave count 5 after E5; a write on the pop edge E861 keeps it
  // at 5. Then reset mid-DATA of the second frame and send a clean frame.
  task automatic test_simultaneous_and_reset;
    for (int c = 0; c <= 1000; c++) begin
      if (c <= 5) begin
        valid[0] = 1'b1;
        data[0]  = 9'h020 + 9'(c);
      end else if (c == 861) begin
        valid[0] = 1'b1;
        data[0]  = 9'h030;
      end else begin
        valid[0] = 1'b0;
      end
      tick;
      if (c == 5 || c == 860 || c == 861 || c == 862) begin
        tests++;
        if (cnt[0] !== 5'd5) begin
          fails++;
          $display("FAIL simul_count@%0d: got %0d want 5", c, cnt[0]);
        end
      end
    end
    valid[0] = 1'b0;
    rst_n    = 1'b0;
    tick;
    tests++;
    if (txd[0] !== 1'b1 || cnt[0] !== 5'd0 || busy[0] !== 1'b0 || ready[0] !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset: txd %b count %0d busy %b ready %b want 1 0 0 1",
               txd[0], cnt[0], busy[0], ready[0]);
    end
    rst_n = 1'b1;
    tick;
    send_and_check(0, 9'h0A3, 12'b0011_0100_0110, 10, "post_reset_a3");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    for (int d = 0; d < 4; d++) begin
      valid[d] = 1'b0;
      data[d]  = '0;
    end
    test_reset;
    test_8n1;
    test_parity;
    test_back_to_back;
    test_simultaneous_and_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
